// File: rtl/ex_stage.sv
// RV32 execute stage: operand forwarding, ALU, branch/jump resolution,
// and the EX/MEM pipeline register with stall and flush.
module ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              JumpE,
  input  logic              BranchE,
  input  logic              ALUSrcE,
  input  logic [1:0]        ResultSrcE,
  input  logic [2:0]        ALUControlE,
  input  logic [REG_AW-1:0] RdE,
  input  logic [XLEN-1:0]   RD1E,
  input  logic [XLEN-1:0]   RD2E,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   ImmExtE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [XLEN-1:0]   ResultW,
  input  logic              StallM,
  input  logic              FlushM,
  output logic              PCSrcE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [REG_AW-1:0] RdM,
  output logic [XLEN-1:0]   ALUResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   PCPlus4M
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_t;

  logic [XLEN-1:0] w_srca;
  logic [XLEN-1:0] w_writedata;
  logic [XLEN-1:0] w_srcb;
  logic [XLEN-1:0] w_alu_result;
  logic [4:0]      w_shamt;
  logic            w_lt;
  logic            w_zero;

  // 2'b11 falls back to the register-file value, same as 2'b00.
  always_comb begin
    w_srca = RD1E;
    unique case (ForwardAE)
      2'b01:   w_srca = ResultW;
      2'b10:   w_srca = ALUResultM;
      default: w_srca = RD1E;
    endcase
  end

  always_comb begin
    w_writedata = RD2E;
    unique case (ForwardBE)
      2'b01:   w_writedata = ResultW;
      2'b10:   w_writedata = ALUResultM;
      default: w_writedata = RD2E;
    endcase
  end

  assign w_srcb  = ALUSrcE ? ImmExtE : w_writedata;
  assign w_shamt = w_srcb[4:0];
  assign w_lt    = $signed(w_srca) < $signed(w_srcb);

  always_comb begin
    w_alu_result = '0;
    unique case (alu_op_t'(ALUControlE))
      ALU_ADD: w_alu_result = w_srca + w_srcb;
      ALU_SUB: w_alu_result = w_srca - w_srcb;
      ALU_AND: w_alu_result = w_srca & w_srcb;
      ALU_OR:  w_alu_result = w_srca | w_srcb;
      ALU_XOR: w_alu_result = w_srca ^ w_srcb;
      ALU_SLT: w_alu_result = {{(XLEN-1){1'b0}}, w_lt};
      ALU_SLL: w_alu_result = w_srca << w_shamt;
      ALU_SRL: w_alu_result = w_srca >> w_shamt;
      default: w_alu_result = '0;
    endcase
  end

  assign w_zero    = (w_alu_result == '0);
  assign PCSrcE    = JumpE | (BranchE & w_zero);
  assign PCTargetE = PCE + ImmExtE;

  always_ff @(posedge clk) begin
    if (reset || FlushM) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      RdM        <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else if (!StallM) begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RdM        <= RdE;
      ALUResultM <= w_alu_result;
      WriteDataM <= w_writedata;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage with hand-computed expectations.
module tb_ex_stage;

  logic        clk;
  logic        reset;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [4:0]  RdE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [31:0] ResultW;
  logic        StallM, FlushM;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  int n_tests = 0;
  int n_fail  = 0;

  ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE), .RdE(RdE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .ImmExtE(ImmExtE), .PCPlus4E(PCPlus4E),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .StallM(StallM), .FlushM(FlushM),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .RdM(RdM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    RegWriteE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0; ALUSrcE = 0;
    ResultSrcE = 0; ALUControlE = 0; RdE = 0;
    RD1E = 0; RD2E = 0; PCE = 0; ImmExtE = 0; PCPlus4E = 0;
    ForwardAE = 0; ForwardBE = 0; ResultW = 0; StallM = 0; FlushM = 0;
  endtask

  task automatic random_inputs();
    RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); JumpE = 1'($urandom);
    BranchE = 1'($urandom); ALUSrcE = 1'($urandom); ResultSrcE = 2'($urandom);
    ALUControlE = 3'($urandom); RdE = 5'($urandom);
    RD1E = $urandom; RD2E = $urandom; PCE = $urandom; ImmExtE = $urandom;
    PCPlus4E = $urandom; ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
    ResultW = $urandom;
  endtask

  task automatic check_m(input string tag, input logic rw, input logic mw, input logic [1:0] rs,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                         input logic [31:0] p4);
    check({tag, ".RegWriteM"},  32'(RegWriteM),  32'(rw));
    check({tag, ".MemWriteM"},  32'(MemWriteM),  32'(mw));
    check({tag, ".ResultSrcM"}, 32'(ResultSrcM), 32'(rs));
    check({tag, ".RdM"},        32'(RdM),        32'(rd));
    check({tag, ".ALUResultM"}, ALUResultM,      alu);
    check({tag, ".WriteDataM"}, WriteDataM,      wd);
    check({tag, ".PCPlus4M"},   PCPlus4M,        p4);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] exp;
    string       name;
  } alu_vec_t;

  alu_vec_t alu_vecs[8];

  initial begin
    alu_vecs[0] = '{3'b000, 32'hFFFFFFF4, "add"};
    alu_vecs[1] = '{3'b001, 32'hFFFFFFEC, "sub"};
    alu_vecs[2] = '{3'b010, 32'h00000000, "and"};
    alu_vecs[3] = '{3'b011, 32'hFFFFFFF4, "or"};
    alu_vecs[4] = '{3'b100, 32'hFFFFFFF4, "xor"};
    alu_vecs[5] = '{3'b101, 32'h00000001, "slt"};
    alu_vecs[6] = '{3'b110, 32'hFFFFFF00, "sll"};
    alu_vecs[7] = '{3'b111, 32'h0FFFFFFF, "srl"};

    // 1: reset with random inputs, then a simple add
    reset = 1;
    random_inputs();
    step();
    random_inputs();
    step();
    check_m("reset", 0, 0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);

    reset = 0;
    idle_inputs();
    RegWriteE = 1; ResultSrcE = 2'b01; RdE = 5'd3; RD1E = 5; RD2E = 7;
    PCPlus4E = 32'h0000_0204; ALUControlE = 3'b000;
    step();
    check_m("add5p7", 1, 0, 2'b01, 5'd3, 32'd12, 32'd7, 32'h0000_0204);

    // 2: ALU sweep with SrcA=0xFFFFFFF0, SrcB=4
    idle_inputs();
    RD1E = 32'hFFFFFFF0; RD2E = 32'd4;
    for (int unsigned i = 0; i < 8; i++) begin
      ALUControlE = alu_vecs[i].op;
      step();
      check({"alu_", alu_vecs[i].name}, ALUResultM, alu_vecs[i].exp);
    end
    // slt signed boundary: 4 < -16 is false
    RD1E = 32'd4; RD2E = 32'hFFFFFFF0; ALUControlE = 3'b101;
    step();
    check("slt_neg_b", ALUResultM, 32'd0);
    // shift uses only SrcB[4:0]: 0x21 -> shift by 1
    RD1E = 32'h8000_0001; RD2E = 32'h0000_0021; ALUControlE = 3'b111;
    step();
    check("srl_shamt5", ALUResultM, 32'h4000_0000);
    // add wraps
    RD1E = 32'hFFFF_FFFF; RD2E = 32'd2; ALUControlE = 3'b000;
    step();
    check("add_wrap", ALUResultM, 32'd1);

    // 3: forwarding
    idle_inputs();
    RD1E = 32'h50; RD2E = 32'h05;
    step();
    check("fwd_setup", ALUResultM, 32'h55);
    RD1E = 32'hDEAD_0000; RD2E = 32'h0000_BEEF; ResultW = 32'h22;
    ForwardAE = 2'b10; ForwardBE = 2'b01; MemWriteE = 1;
    step();
    check("fwd_alu", ALUResultM, 32'h77);
    check("fwd_wd", WriteDataM, 32'h22);
    check("fwd_mw", 32'(MemWriteM), 32'd1);
    // 11 selects register-file operand
    ForwardAE = 2'b11; ForwardBE = 2'b11; RD1E = 32'h10; RD2E = 32'h3; MemWriteE = 0;
    step();
    check("fwd11_alu", ALUResultM, 32'h13);
    check("fwd11_wd", WriteDataM, 32'h3);

    // 4: branch / jump resolution, combinational
    idle_inputs();
    BranchE = 1; ALUControlE = 3'b001; RD1E = 32'd9; RD2E = 32'd9;
    PCE = 32'h100; ImmExtE = 32'hFFFFFFF8;
    #1;
    check("beq_taken", 32'(PCSrcE), 32'd1);
    check("beq_target", PCTargetE, 32'hF8);
    RD2E = 32'd10;
    #1;
    check("beq_not_taken", 32'(PCSrcE), 32'd0);
    BranchE = 0; JumpE = 1;
    #1;
    check("jump", 32'(PCSrcE), 32'd1);
    JumpE = 0; PCE = 32'hFFFF_FFFC; ImmExtE = 32'd8;
    #1;
    check("target_wrap", PCTargetE, 32'd4);
    check("no_redirect", 32'(PCSrcE), 32'd0);

    // 5: stall holds, flush beats stall
    idle_inputs();
    RegWriteE = 1; RdE = 5'd5; ResultSrcE = 2'b10; RD1E = 32'h30; RD2E = 32'h3;
    PCPlus4E = 32'h44;
    step();
    check_m("pre_stall", 1, 0, 2'b10, 5'd5, 32'h33, 32'h3, 32'h44);
    StallM = 1;
    for (int unsigned c = 0; c < 3; c++) begin
      RegWriteE = 0; MemWriteE = 1; RdE = 5'(c + 10); ResultSrcE = 2'b01;
      RD1E = 32'(c * 100 + 1); RD2E = 32'(c + 9); PCPlus4E = 32'(c + 1000);
      step();
      check_m("stall", 1, 0, 2'b10, 5'd5, 32'h33, 32'h3, 32'h44);
    end
    FlushM = 1;
    step();
    check_m("flush_stall", 0, 0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);

    // 6: dependent chain r1=r1+1 through ALUResultM, starting from the bubble's 0
    idle_inputs();
    RegWriteE = 1; RdE = 5'd1; ForwardAE = 2'b10; ALUSrcE = 1; ImmExtE = 32'd1;
    RD1E = 32'hAAAA_AAAA;
    for (int unsigned k = 1; k <= 4; k++) begin
      step();
      check("chain", ALUResultM, 32'(k));
    end

    // mid-stream reset discards the in-flight result
    reset = 1;
    step();
    check_m("mid_reset", 0, 0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    reset = 0;
    step();
    check("after_reset", ALUResultM, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
